hamming_secded_decoder: RTL and testbench
=========================================

HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the data word width (4..64).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of each error counter.
REQ-003 SHALL derive PAR_W as the smallest p with 2^p >= DATA_W+p+1, and N = DATA_W+PAR_W+1 as the codeword width (DATA_W=8 gives N=13).
REQ-004 SHALL use one clock and an asynchronous, active-high reset; ports are listed below.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 code_in  input  N  codeword; bit 0 is overall parity, bit i (1..N-1) is Hamming position i.
REQ-008 in_valid / in_ready  input / output  1 each  input handshake.
REQ-009 data_out  output  DATA_W  corrected data.
REQ-010 syndrome_out  output  PAR_W  raw syndrome of the beat.
REQ-011 err_corr / err_uncorr  output  1 each  single error corrected / uncorrectable error.
REQ-012 out_valid / out_ready  output / input  1 each  output handshake.
REQ-013 clr_cnt  input  1  synchronous counter clear.
REQ-014 corr_cnt / uncorr_cnt  output  CNT_W each  saturating event counters.

Function
REQ-015 SHALL place parity bits at power-of-two positions and data bits at the remaining positions, ascending, with data bit 0 at the lowest data position.
REQ-016 SHALL be a 2-stage pipeline: stage 1 registers the codeword, syndrome s and overall parity p_all (XOR of all N bits); stage 2 registers the corrected data and flags.
REQ-017 SHALL have latency 2: a beat accepted at edge k gives out_valid after edge k+2 when the pipeline is not stalled.
REQ-018 SHALL accept a beat when in_valid && in_ready, and SHALL transfer a beat out when out_valid && out_ready.
REQ-019 SHALL advance stage 2 when it is empty or out_ready=1, and SHALL advance stage 1 when it is empty or stage 2 advances; in_ready equals stage-1-advance, giving full throughput of one beat per cycle.
REQ-020 SHALL hold out_valid and all outputs stable while out_valid=1 && out_ready=0.
REQ-021 SHALL classify the clean case (s==0, p_all==0) as no error: both flags 0.
REQ-022 SHALL treat s==0, p_all==1 as a parity-bit error: err_corr=1, data unchanged.
REQ-023 SHALL treat s in 1..N-1 with p_all==1 by flipping position s: err_corr=1.
REQ-024 SHALL treat s>N-1 with p_all==1 as err_uncorr=1.
REQ-025 SHALL treat s!=0 with p_all==0 as a double error: err_uncorr=1, data_out = uncorrected extracted data.
REQ-026 SHALL never assert err_corr and err_uncorr together.
REQ-027 SHALL increment corr_cnt / uncorr_cnt by 1 on each output transfer carrying the matching flag, saturating at all-ones.
REQ-028 SHALL make clr_cnt zero both counters; clear wins over a same-cycle increment.

Reset
REQ-029 SHALL drive in_ready=1 and out_valid=0 on rst, with both stages empty and data_out, syndrome_out, flags and counters all 0.
REQ-030 SHALL discard in-flight beats when rst asserts mid-operation; no beat emerges after release.

Configuration
REQ-031 With HAMMING_ERR_INJECT_EN defined, SHALL add input inj_mask (width N), XORed into code_in at acceptance.
REQ-032 Without HAMMING_ERR_INJECT_EN, the inj_mask port SHALL be absent and behaviour otherwise identical.

Structure
REQ-033 SHALL take the PAR_W/N computation functions, the position-to-data-bit mapping function and a reference encode function from shared package hamming_pkg.
REQ-034 SHALL instantiate one combinational sub-module, hamming_syndrome, which computes s and p_all.

Verification (DATA_W=8, N=13, HAMMING_ERR_INJECT_EN defined)
REQ-035 Encode 0xA5 with the package function, send it clean -> data_out=0xA5, syndrome 0, flags 0, out_valid 2 cycles after accept.
REQ-036 Send 0xA5 with inj_mask bit 5 set -> syndrome 5, err_corr=1, data_out=0xA5, corr_cnt=1.
REQ-037 Send 0xA5 with inj_mask bit 0 set -> syndrome 0, err_corr=1, data_out=0xA5.
REQ-038 Send 0xA5 with inj_mask bits 3 and 6 set -> syndrome 5, err_uncorr=1, uncorr_cnt=1.
REQ-039 Stream 8 back-to-back beats with out_ready low for cycles 3-5 -> no loss or duplication, order preserved, in_ready low only while stalled.
REQ-040 Assert rst with 2 beats in flight, then clr_cnt together with an error transfer -> no output after release; counters read 0.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared helpers for the Hamming SECDED decoder: code geometry, data-bit
// placement and a reference encoder used by benches and models.
package hamming_pkg;

  localparam int unsigned MAX_DW = 64;
  localparam int unsigned MAX_N  = 72;

  function automatic int unsigned hamming_par_w(input int unsigned dw);
    int unsigned p;
    p = 1;
    while ((32'd1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  function automatic int unsigned hamming_n(input int unsigned dw);
    return dw + hamming_par_w(dw) + 1;
  endfunction

  function automatic logic hamming_is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

  // Codeword position of data bit j: the j-th non-power-of-two position.
  function automatic int unsigned hamming_data_pos(input int unsigned j);
    int unsigned pos;
    int unsigned cnt;
    pos = 0;
    cnt = 0;
    for (int unsigned i = 1; i < MAX_N; i++) begin
      if (!hamming_is_pow2(i)) begin
        if (cnt == j && pos == 0) pos = i;
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic logic [MAX_N-1:0] hamming_encode(input logic [MAX_DW-1:0] data,
                                                      input int unsigned       dw);
    logic [MAX_N-1:0] c;
    logic             par;
    int unsigned      n;
    n = hamming_n(dw);
    c = '0;
    for (int unsigned j = 0; j < dw; j++) c[hamming_data_pos(j)] = data[j];
    for (int unsigned k = 0; k < hamming_par_w(dw); k++) begin
      par = 1'b0;
      for (int unsigned i = 1; i < n; i++)
        if (((i >> k) & 1) != 0) par ^= c[i];
      c[32'd1 << k] = par;
    end
    c[0] = ^c;
    return c;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for one SECDED codeword.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  localparam int unsigned PAR_W  = hamming_par_w(DATA_W),
  localparam int unsigned N      = DATA_W + PAR_W + 1
) (
  input  logic [N-1:0]     i_code,
  output logic [PAR_W-1:0] o_syndrome,
  output logic             o_p_all
);

  always_comb begin
    o_syndrome = '0;
    for (int unsigned k = 0; k < PAR_W; k++)
      for (int unsigned i = 1; i < N; i++)
        if (((i >> k) & 1) != 0) o_syndrome[k] = o_syndrome[k] ^ i_code[i];
    o_p_all = ^i_code;
  end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage SECDED decoder with valid/ready handshakes and saturating error counters.
// Optional HAMMING_ERR_INJECT_EN adds an inj_mask input XORed into code_in at acceptance.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned PAR_W  = hamming_par_w(DATA_W),
  localparam int unsigned N      = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      code_in,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic [N-1:0]      inj_mask,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [PAR_W-1:0]  syndrome_out,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  logic [N-1:0]      w_code;
  logic [PAR_W-1:0]  w_syn;
  logic              w_p_all;
  logic              w_s1_adv;
  logic              w_s2_adv;
  logic              w_xfer;
  logic [31:0]       w_syn_idx;
  logic [N-1:0]      w_fixed;
  logic [DATA_W-1:0] w_data;
  logic              w_corr;
  logic              w_uncorr;

  logic              r_s1_valid;
  logic [N-1:0]      r_s1_code;
  logic [PAR_W-1:0]  r_s1_syn;
  logic              r_s1_pall;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_data;
  logic [PAR_W-1:0]  r_syn;
  logic              r_corr;
  logic              r_uncorr;
  logic [CNT_W-1:0]  r_corr_cnt;
  logic [CNT_W-1:0]  r_uncorr_cnt;

`ifdef HAMMING_ERR_INJECT_EN
  assign w_code = code_in ^ inj_mask;
`else
  assign w_code = code_in;
`endif

  hamming_syndrome #(.DATA_W(DATA_W)) u_syndrome (
    .i_code     (w_code),
    .o_syndrome (w_syn),
    .o_p_all    (w_p_all)
  );

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign w_xfer    = r_s2_valid && out_ready;
  assign w_syn_idx = 32'(r_s1_syn);

  // Syndrome beyond the last position with odd parity cannot be a single flip.
  always_comb begin
    w_fixed  = r_s1_code;
    w_corr   = 1'b0;
    w_uncorr = 1'b0;
    if (r_s1_pall) begin
      if (r_s1_syn == '0) begin
        w_corr = 1'b1;
      end else if (w_syn_idx < N) begin
        w_corr = 1'b1;
        for (int unsigned i = 1; i < N; i++)
          if (i == w_syn_idx) w_fixed[i] = ~r_s1_code[i];
      end else begin
        w_uncorr = 1'b1;
      end
    end else if (r_s1_syn != '0) begin
      w_uncorr = 1'b1;
    end
    w_data = '0;
    for (int unsigned j = 0; j < DATA_W; j++) w_data[j] = w_fixed[hamming_data_pos(j)];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_code    <= '0;
      r_s1_syn     <= '0;
      r_s1_pall    <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_data       <= '0;
      r_syn        <= '0;
      r_corr       <= 1'b0;
      r_uncorr     <= 1'b0;
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_code <= w_code;
          r_s1_syn  <= w_syn;
          r_s1_pall <= w_p_all;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_data   <= w_data;
          r_syn    <= r_s1_syn;
          r_corr   <= w_corr;
          r_uncorr <= w_uncorr;
        end
      end
      if (clr_cnt) begin
        r_corr_cnt   <= '0;
        r_uncorr_cnt <= '0;
      end else if (w_xfer) begin
        if (r_corr && r_corr_cnt != '1)     r_corr_cnt   <= r_corr_cnt + 1'b1;
        if (r_uncorr && r_uncorr_cnt != '1) r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
      end
    end
  end

  assign in_ready     = w_s1_adv;
  assign out_valid    = r_s2_valid;
  assign data_out     = r_data;
  assign syndrome_out = r_syn;
  assign err_corr     = r_corr;
  assign err_uncorr   = r_uncorr;
  assign corr_cnt     = r_corr_cnt;
  assign uncorr_cnt   = r_uncorr_cnt;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench for hamming_secded_decoder (DATA_W=8, N=13); works with or
// without HAMMING_ERR_INJECT_EN by folding the mask into code_in when absent.
module tb_hamming_secded_decoder;
  import hamming_pkg::*;

  localparam int N = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  code_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    data_out;
  logic [3:0]    syndrome_out;
  logic          err_corr, err_uncorr;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          clr_cnt = 1'b0;
  logic [15:0]   corr_cnt, uncorr_cnt;
`ifdef HAMMING_ERR_INJECT_EN
  logic [N-1:0]  inj_mask = '0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hamming_secded_decoder #(.DATA_W(8), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .code_in      (code_in),
`ifdef HAMMING_ERR_INJECT_EN
    .inj_mask     (inj_mask),
`endif
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_out     (data_out),
    .syndrome_out (syndrome_out),
    .err_corr     (err_corr),
    .err_uncorr   (err_uncorr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .clr_cnt      (clr_cnt),
    .corr_cnt     (corr_cnt),
    .uncorr_cnt   (uncorr_cnt)
  );

  function automatic logic [N-1:0] enc8(input logic [7:0] d);
    logic [MAX_N-1:0] t;
    t = hamming_encode(64'(d), 8);
    return t[N-1:0];
  endfunction

  task automatic drive(input logic [N-1:0] cw, input logic [N-1:0] mask);
`ifdef HAMMING_ERR_INJECT_EN
    code_in  = cw;
    inj_mask = mask;
`else
    code_in  = cw ^ mask;
`endif
  endtask

  // Presents one beat right after an edge; lat counts edges from presentation to out_valid.
  task automatic run_beat(input logic [N-1:0] cw, input logic [N-1:0] mask, output int lat,
                          output logic [7:0] d, output logic [3:0] s,
                          output logic c, output logic u);
    logic done;
    drive(cw, mask);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    lat = -1;
    done = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (!done) begin
        @(posedge clk); #1;
        if (i == 1) begin in_valid = 1'b0; drive('0, '0); end
        if (out_valid === 1'b1) begin lat = i; done = 1'b1; end
      end
    end
    d = data_out; s = syndrome_out; c = err_corr; u = err_uncorr;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h want 1", in_ready); end checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %0h want 0", data_out); end checks++;
    if (syndrome_out !== 4'h0) begin errors++; $display("FAIL reset_syn got %0h want 0", syndrome_out); end checks++;
    if ({err_corr, err_uncorr} !== 2'b00) begin errors++; $display("FAIL reset_flags got %0h want 0", {err_corr, err_uncorr}); end checks++;
    if (corr_cnt !== 16'h0 || uncorr_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %0h/%0h want 0/0", corr_cnt, uncorr_cnt); end checks++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clean;
    int lat; logic [7:0] d; logic [3:0] s; logic c, u;
    run_beat(enc8(8'hA5), '0, lat, d, s, c, u);
    if (lat !== 2) begin errors++; $display("FAIL clean_latency got %0d want 2", lat); end checks++;
    if (d !== 8'hA5) begin errors++; $display("FAIL clean_data got %0h want a5", d); end checks++;
    if (s !== 4'h0) begin errors++; $display("FAIL clean_syn got %0h want 0", s); end checks++;
    if ({c, u} !== 2'b00) begin errors++; $display("FAIL clean_flags got %0h want 0", {c, u}); end checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL clean_drain got %0h want 0", out_valid); end checks++;
  endtask

  task automatic test_single;
    int lat; logic [7:0] d; logic [3:0] s; logic c, u;
    run_beat(enc8(8'hA5), 13'h0020, lat, d, s, c, u);
    if (s !== 4'h5) begin errors++; $display("FAIL single_syn got %0h want 5", s); end checks++;
    if ({c, u} !== 2'b10) begin errors++; $display("FAIL single_flags got %0h want 2", {c, u}); end checks++;
    if (d !== 8'hA5) begin errors++; $display("FAIL single_data got %0h want a5", d); end checks++;
    if (corr_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", corr_cnt); end checks++;
    run_beat(enc8(8'hA5), 13'h1000, lat, d, s, c, u);
    if (s !== 4'hC || {c, u} !== 2'b10 || d !== 8'hA5) begin
      errors++; $display("FAIL top_pos got %0h/%0h/%0h want c/2/a5", s, {c, u}, d); end checks++;
  endtask

  task automatic test_parity_bit;
    int lat; logic [7:0] d; logic [3:0] s; logic c, u;
    run_beat(enc8(8'hA5), 13'h0001, lat, d, s, c, u);
    if (s !== 4'h0) begin errors++; $display("FAIL pbit_syn got %0h want 0", s); end checks++;
    if ({c, u} !== 2'b10) begin errors++; $display("FAIL pbit_flags got %0h want 2", {c, u}); end checks++;
    if (d !== 8'hA5) begin errors++; $display("FAIL pbit_data got %0h want a5", d); end checks++;
    if (corr_cnt !== 16'd3) begin errors++; $display("FAIL pbit_cnt got %0d want 3", corr_cnt); end checks++;
  endtask

  task automatic test_double;
    int lat; logic [7:0] d; logic [3:0] s; logic c, u;
    run_beat(enc8(8'hA5), 13'h0048, lat, d, s, c, u);
    if (s !== 4'h5) begin errors++; $display("FAIL double_syn got %0h want 5", s); end checks++;
    if ({c, u} !== 2'b01) begin errors++; $display("FAIL double_flags got %0h want 1", {c, u}); end checks++;
    if (d !== 8'hA0) begin errors++; $display("FAIL double_data got %0h want a0", d); end checks++;
    if (uncorr_cnt !== 16'd1 || corr_cnt !== 16'd3) begin
      errors++; $display("FAIL double_cnt got %0d/%0d want 3/1", corr_cnt, uncorr_cnt); end checks++;
    run_beat(enc8(8'hA5), 13'h0112, lat, d, s, c, u);
    if (s !== 4'hD || {c, u} !== 2'b01 || d !== 8'hA5) begin
      errors++; $display("FAIL beyond_range got %0h/%0h/%0h want d/1/a5", s, {c, u}, d); end checks++;
    if (uncorr_cnt !== 16'd2) begin errors++; $display("FAIL beyond_cnt got %0d want 2", uncorr_cnt); end checks++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] vals [8] = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h5A, 8'h12, 8'hE7, 8'h99};
    logic [7:0] rx [8];
    int sent = 0, nrx = 0, bad = 0, extra = 0;
    logic stall_seen = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (nrx < 8) begin
        out_ready = !(t >= 3 && t <= 5);
        in_valid  = (sent < 8);
        drive((sent < 8) ? enc8(vals[sent]) : '0, '0);
        @(negedge clk);
        if (!in_ready) stall_seen = 1'b1;
        if (!in_ready && out_ready) bad++;
        if (in_valid && in_ready) sent++;
        if (out_valid && out_ready) begin rx[nrx] = data_out; nrx++; end
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin @(negedge clk); if (out_valid) extra++; end
    if (nrx !== 8) begin errors++; $display("FAIL b2b_count got %0d want 8", nrx); end checks++;
    for (int i = 0; i < 8; i++) begin
      if (i < nrx) begin
        if (rx[i] !== vals[i]) begin errors++; $display("FAIL b2b_beat%0d got %0h want %0h", i, rx[i], vals[i]); end checks++;
      end
    end
    if (bad !== 0) begin errors++; $display("FAIL b2b_ready_unstalled got %0d want 0", bad); end checks++;
    if (stall_seen !== 1'b1) begin errors++; $display("FAIL b2b_backpressure got %0h want 1", stall_seen); end checks++;
    if (extra !== 0) begin errors++; $display("FAIL b2b_duplicate got %0d want 0", extra); end checks++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_flush;
    int seen = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(enc8(8'h3C), 13'h0020);
    @(posedge clk); #1;
    drive(enc8(8'hC3), 13'h0048);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drive('0, '0);
    rst = 1'b1;
    #1;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_async got %0h want 0", out_valid); end checks++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin @(negedge clk); if (out_valid !== 1'b0) seen++; end
    if (seen !== 0) begin errors++; $display("FAIL flush_no_output got %0d want 0", seen); end checks++;
    if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
      errors++; $display("FAIL flush_cnt got %0d/%0d want 0/0", corr_cnt, uncorr_cnt); end checks++;
    @(posedge clk); #1;
  endtask

  task automatic test_clear;
    int lat; logic [7:0] d; logic [3:0] s; logic c, u;
    logic done = 1'b0;
    run_beat(enc8(8'h5A), 13'h0020, lat, d, s, c, u);
    if (corr_cnt !== 16'd1) begin errors++; $display("FAIL clr_pre got %0d want 1", corr_cnt); end checks++;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(enc8(8'h5A), 13'h0048);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!done) begin
        if (out_valid === 1'b1) done = 1'b1;
        else begin @(posedge clk); #1; end
      end
    end
    if (done !== 1'b1) begin errors++; $display("FAIL clr_wait got timeout want out_valid"); end checks++;
    if (err_uncorr !== 1'b1) begin errors++; $display("FAIL clr_flag got %0h want 1", err_uncorr); end checks++;
    clr_cnt   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
      errors++; $display("FAIL clr_wins got %0d/%0d want 0/0", corr_cnt, uncorr_cnt); end checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_transfer got %0h want 0", out_valid); end checks++;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_parity_bit();
    test_double();
    test_back_to_back();
    test_reset_flush();
    test_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
